display_scan_controller: RTL and testbench

Sequences the multiplexed 4-digit seven-segment display of the speedometer. It accepts a binary speed value on a stb/ack input stream and converts it to BCD sequentially. It then scans the digits forever, emitting a segment-pattern word and a digit-select word per digit on two stb/ack output streams. Those streams feed the existing resizer/device_pin_output chains.

---
 rtl/display_pkg.sv | 22 ++
 rtl/display_scan_controller_if.sv | 16 +
 rtl/bin_to_bcd_seq.sv | 68 ++++++
 rtl/display_scan_controller.sv | 77 +++++++
 tb/tb_display_scan_controller.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// display_pkg: segment codes, digit count and FSM encodings shared by the scan controller.
package display_pkg;
  localparam int DIGIT_COUNT = 4;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  typedef enum logic [2:0] {CV_IDLE, CV_CLAMP, CV_SUB1000, CV_SUB100, CV_SUB10, CV_COMMIT} conv_state_t;
  typedef enum logic [1:0] {SC_WAIT, SC_SEG, SC_SEL} scan_state_t;
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    return d == 4'd0 ? SEG_0 : d == 4'd1 ? SEG_1 : d == 4'd2 ? SEG_2 : d == 4'd3 ? SEG_3 :
           d == 4'd4 ? SEG_4 : d == 4'd5 ? SEG_5 : d == 4'd6 ? SEG_6 : d == 4'd7 ? SEG_7 :
           d == 4'd8 ? SEG_8 : d == 4'd9 ? SEG_9 : SEG_BLANK;
  endfunction
endpackage

// File: rtl/display_scan_controller_if.sv
// display_scan_controller_if: speed input stream plus segment and digit-select output streams.
interface display_scan_controller_if #(parameter int BITS = 16);
  logic [BITS-1:0] in1;
  logic in1_stb;
  logic in1_ack;
  logic [BITS-1:0] seg_out;
  logic seg_out_stb;
  logic seg_out_ack;
  logic [BITS-1:0] sel_out;
  logic sel_out_stb;
  logic sel_out_ack;
  modport master (output in1, in1_stb, seg_out_ack, sel_out_ack,
                  input in1_ack, seg_out, seg_out_stb, sel_out, sel_out_stb);
  modport slave (input in1, in1_stb, seg_out_ack, sel_out_ack,
                 output in1_ack, seg_out, seg_out_stb, sel_out, sel_out_stb);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD by repeated subtraction, clamped to 9999.
module bin_to_bcd_seq import display_pkg::*; #(
  parameter int BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [BITS-1:0] in_i,
  input  logic stb_i,
  output logic ack_o,
  output logic [4*DIGIT_COUNT-1:0] digits_o,
  output logic commit_o
);
  localparam logic [BITS-1:0] K9999 = BITS'(9999);
  localparam logic [BITS-1:0] K1000 = BITS'(1000);
  localparam logic [BITS-1:0] K100 = BITS'(100);
  localparam logic [BITS-1:0] K10 = BITS'(10);
  conv_state_t state_q;
  logic ack_q;
  logic [BITS-1:0] res_q;
  logic [3:0] th_q, hu_q, te_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CV_IDLE;
      ack_q <= 1'b0;
      res_q <= '0;
      th_q <= '0;
      hu_q <= '0;
      te_q <= '0;
    end else begin
      case (state_q)
        CV_IDLE: begin
          ack_q <= stb_i && !ack_q;
          if (stb_i && ack_q) begin
            ack_q <= 1'b0;
            res_q <= in_i;
            th_q <= '0;
            hu_q <= '0;
            te_q <= '0;
            state_q <= CV_CLAMP;
          end
        end
        CV_CLAMP: begin
          res_q <= res_q > K9999 ? K9999 : res_q;
          state_q <= CV_SUB1000;
        end
        CV_SUB1000:
          if (res_q >= K1000) begin
            res_q <= res_q - K1000;
            th_q <= th_q + 4'd1;
          end else state_q <= CV_SUB100;
        CV_SUB100:
          if (res_q >= K100) begin
            res_q <= res_q - K100;
            hu_q <= hu_q + 4'd1;
          end else state_q <= CV_SUB10;
        CV_SUB10:
          if (res_q >= K10) begin
            res_q <= res_q - K10;
            te_q <= te_q + 4'd1;
          end else state_q <= CV_COMMIT;
        default: state_q <= CV_IDLE;
      endcase
    end
  end
  assign ack_o = ack_q;
  assign digits_o = {th_q, hu_q, te_q, res_q[3:0]};
  assign commit_o = state_q == CV_COMMIT;
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: converts speed to BCD and scans four blanked seven-segment digits.
module display_scan_controller import display_pkg::*; #(
  parameter int BITS = 16,
  parameter int DIGITS = 4,
  parameter int REFRESH_CYCLES = 50000
) (
  input logic clk,
  input logic rst,
  display_scan_controller_if.slave bus
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CYCLES - 1);
  logic [4*DIGIT_COUNT-1:0] digits, dig_q;
  logic commit;
  scan_state_t state_q;
  logic [1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic [6:0] seg_q;
  logic [3:0] sel_q;
  logic seg_stb_q, sel_stb_q;
  logic [3:0] cur;
  logic blank;
  logic [6:0] code;
  bin_to_bcd_seq #(.BITS(BITS)) u_conv (
    .clk(clk), .rst(rst), .in_i(bus.in1), .stb_i(bus.in1_stb), .ack_o(bus.in1_ack),
    .digits_o(digits), .commit_o(commit)
  );
  // a digit blanks only while it and every more significant digit are zero
  always_comb begin
    cur = dig_q[{idx_q, 2'b00} +: 4];
    blank = idx_q == 2'd3 ? dig_q[15:12] == 4'd0 :
            idx_q == 2'd2 ? dig_q[15:8] == 8'd0 :
            idx_q == 2'd1 ? dig_q[15:4] == 12'd0 : 1'b0;
    code = blank ? SEG_BLANK : seg_code(cur);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q <= '0;
      state_q <= SC_WAIT;
      idx_q <= '0;
      cnt_q <= '0;
      seg_q <= '0;
      sel_q <= '0;
      seg_stb_q <= 1'b0;
      sel_stb_q <= 1'b0;
    end else begin
      if (commit) dig_q <= digits;
      case (state_q)
        SC_WAIT:
          if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            seg_q <= code;
            seg_stb_q <= 1'b1;
            state_q <= SC_SEG;
          end else cnt_q <= cnt_q + CW'(1);
        SC_SEG:
          if (bus.seg_out_ack) begin
            seg_stb_q <= 1'b0;
            sel_q <= 4'b0001 << idx_q;
            sel_stb_q <= 1'b1;
            state_q <= SC_SEL;
          end
        SC_SEL:
          if (bus.sel_out_ack) begin
            sel_stb_q <= 1'b0;
            idx_q <= idx_q == 2'(DIGITS - 1) ? 2'd0 : idx_q + 2'd1;
            state_q <= SC_WAIT;
          end
        default: state_q <= SC_WAIT;
      endcase
    end
  end
  assign bus.seg_out = {{(BITS-7){1'b0}}, seg_q};
  assign bus.seg_out_stb = seg_stb_q;
  assign bus.sel_out = {{(BITS-4){1'b0}}, sel_q};
  assign bus.sel_out_stb = sel_stb_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: vector table and scoreboard of scanned (seg, sel) words.
module tb_display_scan_controller;
  typedef struct packed {logic [15:0] seg; logic [15:0] sel;} pair_t;
  typedef struct packed {logic send; logic [15:0] val; logic [3:0][6:0] s;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  pair_t obs[$];
  pair_t exp_q[$];
  int acc_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [15:0] last_seg = '0;
  vec_t tbl[9];
  always #5 clk = ~clk;
  display_scan_controller_if #(.BITS(16)) bus ();
  display_scan_controller #(.BITS(16), .DIGITS(4), .REFRESH_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always @(posedge clk) cyc <= cyc + 1;
  // transfers are recorded half a cycle before the edge that completes them
  always @(negedge clk) if (!rst) begin
    if (bus.in1_stb && bus.in1_ack) acc_q.push_back(cyc);
    if (bus.seg_out_stb && bus.seg_out_ack) last_seg = bus.seg_out;
    if (bus.sel_out_stb && bus.sel_out_ack) obs.push_back({last_seg, bus.sel_out});
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic push_scan(input logic [3:0][6:0] s);
    for (int i = 0; i < 4; i++) exp_q.push_back({{9'd0, s[i]}, 16'(1 << i)});
  endtask
  task automatic check_scan(input bit sync, input int cnt);
    int n = 0;
    int t = 0;
    pair_t o, e;
    obs.delete();
    while (n < cnt && t < 400) begin
      @(posedge clk);
      t++;
      while (obs.size() > 0 && n < cnt) begin
        o = obs.pop_front();
        if (sync && n == 0 && o.sel != 16'h0001) continue;
        e = exp_q.pop_front();
        chk($sformatf("word%0d_seg", n), o.seg, e.seg);
        chk($sformatf("word%0d_sel", n), o.sel, e.sel);
        n++;
      end
    end
    chk("scan_words_seen", n, cnt);
    exp_q.delete();
  endtask
  task automatic send(input logic [15:0] v, output int lat);
    bus.in1 = v;
    bus.in1_stb = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!bus.in1_ack && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("in1_ack_seen", bus.in1_ack, 1);
    @(posedge clk);
    #1 bus.in1_stb = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_in1_ack"}, bus.in1_ack, 0);
    chk({tag, "_seg_stb"}, bus.seg_out_stb, 0);
    chk({tag, "_sel_stb"}, bus.sel_out_stb, 0);
    chk({tag, "_seg_out"}, bus.seg_out, 0);
    chk({tag, "_sel_out"}, bus.sel_out, 0);
  endtask
  task automatic wait_seg_stb();
    int t = 0;
    while (!bus.seg_out_stb && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("seg_stb_seen", bus.seg_out_stb, 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, n0, gap;
    logic ok;
    logic [15:0] held;
    tbl[0] = '{1'b0, 16'd0, {7'h00, 7'h00, 7'h00, 7'h3F}};
    tbl[1] = '{1'b1, 16'd1234, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    tbl[2] = '{1'b1, 16'd12000, {7'h6F, 7'h6F, 7'h6F, 7'h6F}};
    tbl[3] = '{1'b1, 16'd7, {7'h00, 7'h00, 7'h00, 7'h07}};
    tbl[4] = '{1'b1, 16'd10, {7'h00, 7'h00, 7'h06, 7'h3F}};
    tbl[5] = '{1'b1, 16'd100, {7'h00, 7'h06, 7'h3F, 7'h3F}};
    tbl[6] = '{1'b1, 16'd1000, {7'h06, 7'h3F, 7'h3F, 7'h3F}};
    tbl[7] = '{1'b1, 16'd65535, {7'h6F, 7'h6F, 7'h6F, 7'h6F}};
    tbl[8] = '{1'b1, 16'd0, {7'h00, 7'h00, 7'h00, 7'h3F}};
    bus.in1 = '0;
    bus.in1_stb = 1'b0;
    bus.seg_out_ack = 1'b1;
    bus.sel_out_ack = 1'b1;
    #1 chk_zero("reset");
    #22 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].send) begin
        send(tbl[i].val, lat);
        chk($sformatf("vec%0d_ack_lat", i), lat <= 1, 1);
        repeat (40) @(posedge clk);
      end
      push_scan(tbl[i].s);
      check_scan(1'b1, 4);
    end
    // segment backpressure: the stalled word and the index must not move
    send(16'd1234, lat);
    repeat (40) @(posedge clk);
    push_scan({7'h06, 7'h5B, 7'h4F, 7'h66});
    check_scan(1'b1, 4);
    #1 bus.seg_out_ack = 1'b0;
    wait_seg_stb();
    held = bus.seg_out;
    chk("stall_seg_word", held, 16'h0066);
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!bus.seg_out_stb || bus.seg_out != held || bus.sel_out_stb) ok = 1'b0;
    end
    chk("stall_hold", ok, 1);
    @(posedge clk);
    #1 bus.seg_out_ack = 1'b1;
    exp_q.push_back({16'h0066, 16'h0001});
    exp_q.push_back({16'h004F, 16'h0002});
    check_scan(1'b0, 2);
    // back-to-back inputs: the second waits for the first to commit
    n0 = acc_q.size();
    send(16'd9999, lat);
    send(16'd5, lat);
    chk("accept_count", acc_q.size() - n0, 2);
    gap = acc_q.size() >= n0 + 2 ? acc_q[n0+1] - acc_q[n0] : 0;
    chk("accept_gap_ok", gap >= 32 && gap <= 40, 1);
    repeat (40) @(posedge clk);
    push_scan({7'h00, 7'h00, 7'h00, 7'h6D});
    check_scan(1'b1, 4);
    // asynchronous reset mid-conversion with a segment word pending
    #1 bus.seg_out_ack = 1'b0;
    wait_seg_stb();
    @(posedge clk);
    #1;
    send(16'd9999, lat);
    chk("stall_ack_lat", lat <= 1, 1);
    repeat (5) @(posedge clk);
    chk("pre_reset_seg_stb", bus.seg_out_stb, 1);
    #3 rst = 1'b1;
    #1 chk_zero("async_reset");
    #13 rst = 1'b0;
    bus.seg_out_ack = 1'b1;
    push_scan({7'h00, 7'h00, 7'h00, 7'h3F});
    check_scan(1'b1, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
